// File: rtl/mat_pkg.sv
// Shared types for the row-organised complex matrix store: element/row layout and FSM states.
package mat_pkg;

    localparam int CPLX_WIDTH = 64;
    localparam int MAT_SIZE   = 4;

    // Element layout is {imag, real}; 'real' is a keyword, so the field is called re.
    typedef struct packed {
        logic [CPLX_WIDTH-1:0] imag;
        logic [CPLX_WIDTH-1:0] re;
    } cplx_t;

    typedef cplx_t [MAT_SIZE-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SERVE,
        UNLOAD
    } state_e;

    function automatic logic addr_in_range(input int addr, input int size);
        return addr < size;
    endfunction

endpackage

// File: rtl/row_ram.sv
// Row storage: SIZE rows, one synchronous write port and one combinational read port.
module row_ram #(
    parameter int SIZE   = 4,
    parameter int ROW_W  = 512,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ROW_W-1:0]  rd_row
);

    logic [ROW_W-1:0] mem [SIZE];

    // Storage is intentionally not reset; the caller guarantees in-range write addresses.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_row;
        end
    end

    assign rd_row = mem[rd_addr];

endmodule

// File: rtl/mat_row_responder.sv
// Matrix row store between host DMA and one matrix engine: load, serve row fetch/writeback, unload.
module mat_row_responder
    import mat_pkg::*;
#(
    parameter  int SIZE   = MAT_SIZE,
    parameter  int WIDTH  = CPLX_WIDTH,
    localparam int ADDR_W = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int ROW_W  = SIZE * 2 * WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              host_wr_valid_i,
    output logic              host_wr_ready_o,
    input  logic [ADDR_W-1:0] host_wr_addr_i,
    input  logic [ROW_W-1:0]  host_wr_row_i,
    input  logic              host_load_done_i,
    input  logic [ADDR_W-1:0] eng_rd_addr_i,
    input  logic              eng_rd_addr_valid_i,
    output logic [ROW_W-1:0]  eng_rd_row_o,
    output logic [ADDR_W-1:0] eng_rd_addr_o,
    output logic              eng_rd_valid_o,
    input  logic [ROW_W-1:0]  eng_wr_row_i,
    input  logic [ADDR_W-1:0] eng_wr_addr_i,
    input  logic              eng_wr_valid_i,
    output logic              eng_wr_ready_o,
    input  logic              eng_done_i,
    output logic [ROW_W-1:0]  host_rd_row_o,
    output logic [ADDR_W-1:0] host_rd_addr_o,
    output logic              host_rd_valid_o,
    input  logic              host_rd_ready_i,
    output logic              busy_o,
    output logic              err_o
);

    state_e state;
    state_e state_next;

    logic              in_host_phase;
    logic              in_serve;
    logic              in_unload;
    logic              host_wr_fire;
    logic              host_wr_in_range;
    logic              eng_wr_in_range;
    logic              eng_rd_in_range;
    logic              eng_wr_take;
    logic              eng_rd_take;
    logic              bypass;
    logic              unload_fire;
    logic              unload_last;
    logic              err_event;

    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [ROW_W-1:0]  ram_wr_row;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [ROW_W-1:0]  ram_rd_row;
    logic [ROW_W-1:0]  rd_row_next;

    assign in_host_phase = (state == IDLE) || (state == LOAD);
    assign in_serve      = (state == SERVE);
    assign in_unload     = (state == UNLOAD);

    assign host_wr_ready_o = in_host_phase && !rst_i;
    assign eng_wr_ready_o  = in_serve && !rst_i;
    assign busy_o          = (state != IDLE);

    assign host_wr_in_range = addr_in_range(int'(host_wr_addr_i), SIZE);
    assign eng_wr_in_range  = addr_in_range(int'(eng_wr_addr_i), SIZE);
    assign eng_rd_in_range  = addr_in_range(int'(eng_rd_addr_i), SIZE);

    assign host_wr_fire = host_wr_valid_i && host_wr_ready_o;
    assign eng_wr_take  = in_serve && eng_wr_valid_i;
    assign eng_rd_take  = in_serve && eng_rd_addr_valid_i;

    // Host and engine writes live in disjoint states, so a simple mux shares the write port.
    assign ram_wr_en   = (host_wr_fire && host_wr_in_range) || (eng_wr_take && eng_wr_in_range);
    assign ram_wr_addr = in_serve ? eng_wr_addr_i : host_wr_addr_i;
    assign ram_wr_row  = in_serve ? eng_wr_row_i  : host_wr_row_i;

    // Engine reads are only honoured in SERVE, so UNLOAD can borrow the single read port.
    assign ram_rd_addr = in_unload ? host_rd_addr_o : eng_rd_addr_i;

    assign bypass = eng_wr_take && eng_wr_in_range && (eng_wr_addr_i == eng_rd_addr_i);

    always_comb begin
        rd_row_next = ram_rd_row;
        if (!eng_rd_in_range) begin
            rd_row_next = '0;
        end else if (bypass) begin
            rd_row_next = eng_wr_row_i;
        end
    end

    assign unload_fire = in_unload && host_rd_valid_o && host_rd_ready_i;
    assign unload_last = (host_rd_addr_o == ADDR_W'(SIZE - 1));

    // Memory is frozen during UNLOAD, so the combinational row is stable across host stalls.
    assign host_rd_row_o = host_rd_valid_o ? ram_rd_row : '0;

    always_comb begin
        err_event = 1'b0;
        if (host_wr_valid_i && !in_host_phase) begin
            err_event = 1'b1;
        end
        if (host_wr_fire && !host_wr_in_range) begin
            err_event = 1'b1;
        end
        if ((eng_rd_addr_valid_i || eng_wr_valid_i) && !in_serve) begin
            err_event = 1'b1;
        end
        if ((eng_rd_take && !eng_rd_in_range) || (eng_wr_take && !eng_wr_in_range)) begin
            err_event = 1'b1;
        end
        if (eng_done_i && !in_serve) begin
            err_event = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (host_wr_valid_i)               state_next = LOAD;
            LOAD:    if (host_load_done_i)              state_next = SERVE;
            SERVE:   if (eng_done_i)                    state_next = UNLOAD;
            UNLOAD:  if (unload_fire && unload_last)    state_next = IDLE;
            default:                                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Response register, unload cursor and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            eng_rd_valid_o  <= 1'b0;
            eng_rd_addr_o   <= '0;
            eng_rd_row_o    <= '0;
            host_rd_valid_o <= 1'b0;
            host_rd_addr_o  <= '0;
            err_o           <= 1'b0;
        end else begin
            eng_rd_valid_o <= eng_rd_take;
            if (eng_rd_take) begin
                eng_rd_addr_o <= eng_rd_addr_i;
                eng_rd_row_o  <= rd_row_next;
            end
            if (in_serve && eng_done_i) begin
                host_rd_valid_o <= 1'b1;
                host_rd_addr_o  <= '0;
            end else if (unload_fire) begin
                if (unload_last) begin
                    host_rd_valid_o <= 1'b0;
                    host_rd_addr_o  <= '0;
                end else begin
                    host_rd_addr_o  <= host_rd_addr_o + ADDR_W'(1);
                end
            end
            if (err_event) begin
                err_o <= 1'b1;
            end
        end
    end

    row_ram #(
        .SIZE   (SIZE),
        .ROW_W  (ROW_W),
        .ADDR_W (ADDR_W)
    ) u_row_ram (
        .clk     (clk_i),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_row  (ram_wr_row),
        .rd_addr (ram_rd_addr),
        .rd_row  (ram_rd_row)
    );

endmodule

// File: tb/tb_mat_row_responder.sv
// Directed bench: a SIZE=4 instance for the main flow and a SIZE=3 instance for out-of-range addressing.
module tb_mat_row_responder;

    localparam logic [63:0] D1 = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D2 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D3 = 64'h4008_0000_0000_0000;

    typedef struct {
        logic         rd_v;
        logic [1:0]   rd_a;
        logic         wr_v;
        logic [1:0]   wr_a;
        logic [511:0] wr_row;
        logic         exp_v;
        logic [1:0]   exp_a;
        logic [511:0] exp_row;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst4, rst3;
    logic         host_wr_valid, host_load_done, eng_rd_addr_valid, eng_wr_valid, eng_done, host_rd_ready;
    logic [1:0]   host_wr_addr, eng_rd_addr, eng_wr_addr;
    logic [511:0] host_wr_row, eng_wr_row;

    logic         a_host_wr_ready, a_eng_rd_valid, a_eng_wr_ready, a_host_rd_valid, a_busy, a_err;
    logic [1:0]   a_eng_rd_addr, a_host_rd_addr;
    logic [511:0] a_eng_rd_row, a_host_rd_row;

    logic         b_host_wr_ready, b_eng_rd_valid, b_eng_wr_ready, b_host_rd_valid, b_busy, b_err;
    logic [1:0]   b_eng_rd_addr, b_host_rd_addr;
    logic [383:0] b_eng_rd_row, b_host_rd_row;

    int           n_vec = 0;
    int           n_miss = 0;
    vec_t         vecs[9];
    vec_t         vecs3[3];
    logic [511:0] exp_mem[4];
    logic         pat[6];

    mat_row_responder #(.SIZE(4), .WIDTH(64)) dut4 (
        .clk_i(clk), .rst_i(rst4),
        .host_wr_valid_i(host_wr_valid), .host_wr_ready_o(a_host_wr_ready),
        .host_wr_addr_i(host_wr_addr), .host_wr_row_i(host_wr_row),
        .host_load_done_i(host_load_done),
        .eng_rd_addr_i(eng_rd_addr), .eng_rd_addr_valid_i(eng_rd_addr_valid),
        .eng_rd_row_o(a_eng_rd_row), .eng_rd_addr_o(a_eng_rd_addr), .eng_rd_valid_o(a_eng_rd_valid),
        .eng_wr_row_i(eng_wr_row), .eng_wr_addr_i(eng_wr_addr), .eng_wr_valid_i(eng_wr_valid),
        .eng_wr_ready_o(a_eng_wr_ready), .eng_done_i(eng_done),
        .host_rd_row_o(a_host_rd_row), .host_rd_addr_o(a_host_rd_addr), .host_rd_valid_o(a_host_rd_valid),
        .host_rd_ready_i(host_rd_ready), .busy_o(a_busy), .err_o(a_err)
    );

    mat_row_responder #(.SIZE(3), .WIDTH(64)) dut3 (
        .clk_i(clk), .rst_i(rst3),
        .host_wr_valid_i(host_wr_valid), .host_wr_ready_o(b_host_wr_ready),
        .host_wr_addr_i(host_wr_addr), .host_wr_row_i(host_wr_row[383:0]),
        .host_load_done_i(host_load_done),
        .eng_rd_addr_i(eng_rd_addr), .eng_rd_addr_valid_i(eng_rd_addr_valid),
        .eng_rd_row_o(b_eng_rd_row), .eng_rd_addr_o(b_eng_rd_addr), .eng_rd_valid_o(b_eng_rd_valid),
        .eng_wr_row_i(eng_wr_row[383:0]), .eng_wr_addr_i(eng_wr_addr), .eng_wr_valid_i(eng_wr_valid),
        .eng_wr_ready_o(b_eng_wr_ready), .eng_done_i(eng_done),
        .host_rd_row_o(b_host_rd_row), .host_rd_addr_o(b_host_rd_addr), .host_rd_valid_o(b_host_rd_valid),
        .host_rd_ready_i(host_rd_ready), .busy_o(b_busy), .err_o(b_err)
    );

    function automatic logic [511:0] ident_row(input int i);
        logic [511:0] r;
        r = '0;
        r[i*128 +: 64] = D1;
        return r;
    endfunction

    function automatic logic [511:0] fill_row(input logic [63:0] re, input logic [63:0] im);
        logic [511:0] r;
        for (int j = 0; j < 4; j++) r[j*128 +: 128] = {im, re};
        return r;
    endfunction

    function automatic logic [511:0] seq_row(input int seed);
        logic [511:0] r;
        for (int j = 0; j < 8; j++) r[j*64 +: 64] = 64'(seed * 256 + j + 1);
        return r;
    endfunction

    function automatic vec_t mk(input logic rd_v, input logic [1:0] rd_a, input logic wr_v,
                                input logic [1:0] wr_a, input logic [511:0] wr_row,
                                input logic exp_v, input logic [1:0] exp_a, input logic [511:0] exp_row);
        vec_t v;
        v.rd_v = rd_v; v.rd_a = rd_a; v.wr_v = wr_v; v.wr_a = wr_a; v.wr_row = wr_row;
        v.exp_v = exp_v; v.exp_a = exp_a; v.exp_row = exp_row;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [1:0] addr, input logic [511:0] row);
        host_wr_valid = 1'b1;
        host_wr_addr  = addr;
        host_wr_row   = row;
        tick();
        host_wr_valid = 1'b0;
    endtask

    task automatic pulse_load_done();
        host_load_done = 1'b1;
        tick();
        host_load_done = 1'b0;
    endtask

    task automatic pulse_eng_done();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        eng_rd_addr_valid = v.rd_v;
        eng_rd_addr       = v.rd_a;
        eng_wr_valid      = v.wr_v;
        eng_wr_addr       = v.wr_a;
        eng_wr_row        = v.wr_row;
        tick();
    endtask

    task automatic idle_engine();
        eng_rd_addr_valid = 1'b0;
        eng_wr_valid      = 1'b0;
    endtask

    task automatic run_unload();
        int idx;
        idx = 0;
        for (int k = 0; k < 6 && idx < 4; k++) begin
            check_val("unload_valid", int'(a_host_rd_valid), 1);
            check_val("unload_addr", int'(a_host_rd_addr), idx);
            checkOutput("unload_row", a_host_rd_row, exp_mem[idx]);
            host_rd_ready = pat[k];
            tick();
            if (pat[k]) idx++;
        end
        host_rd_ready = 1'b0;
        check_val("unload_end_valid", int'(a_host_rd_valid), 0);
        check_val("unload_end_busy", int'(a_busy), 0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst4 = 1'b1; rst3 = 1'b1;
        host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_row = '0; host_load_done = 1'b0;
        eng_rd_addr_valid = 1'b0; eng_rd_addr = '0; eng_wr_valid = 1'b0; eng_wr_addr = '0;
        eng_wr_row = '0; eng_done = 1'b0; host_rd_ready = 1'b0;

        vecs[0] = mk(1'b1, 2'd0, 1'b0, 2'd0, '0, 1'b1, 2'd0, ident_row(0));
        vecs[1] = mk(1'b1, 2'd1, 1'b0, 2'd0, '0, 1'b1, 2'd1, ident_row(1));
        vecs[2] = mk(1'b1, 2'd2, 1'b0, 2'd0, '0, 1'b1, 2'd2, ident_row(2));
        vecs[3] = mk(1'b1, 2'd3, 1'b0, 2'd0, '0, 1'b1, 2'd3, ident_row(3));
        vecs[4] = mk(1'b1, 2'd2, 1'b1, 2'd2, fill_row(D2, D3), 1'b1, 2'd2, fill_row(D2, D3));
        vecs[5] = mk(1'b1, 2'd2, 1'b0, 2'd0, '0, 1'b1, 2'd2, fill_row(D2, D3));
        vecs[6] = mk(1'b0, 2'd0, 1'b0, 2'd0, '0, 1'b0, 2'd2, fill_row(D2, D3));
        vecs[7] = mk(1'b1, 2'd1, 1'b1, 2'd0, seq_row(7), 1'b1, 2'd1, ident_row(1));
        vecs[8] = mk(1'b1, 2'd0, 1'b0, 2'd0, '0, 1'b1, 2'd0, seq_row(7));

        // SIZE=3 instance: address 3 is out of range, and a write there must not be bypassed.
        vecs3[0] = mk(1'b1, 2'd3, 1'b0, 2'd0, '0, 1'b1, 2'd3, '0);
        vecs3[1] = mk(1'b1, 2'd2, 1'b0, 2'd0, '0, 1'b1, 2'd2, seq_row(12));
        vecs3[2] = mk(1'b1, 2'd3, 1'b1, 2'd3, seq_row(13), 1'b1, 2'd3, '0);

        $display("[TB] reset state");
        tick(); tick();
        check_val("rst_host_wr_ready", int'(a_host_wr_ready), 0);
        check_val("rst_busy", int'(a_busy), 0);
        rst4 = 1'b0;
        tick();
        check_val("idle_host_wr_ready", int'(a_host_wr_ready), 1);
        check_val("idle_eng_wr_ready", int'(a_eng_wr_ready), 0);
        check_val("idle_busy", int'(a_busy), 0);
        check_val("idle_err", int'(a_err), 0);
        check_val("idle_eng_rd_valid", int'(a_eng_rd_valid), 0);
        check_val("idle_host_rd_valid", int'(a_host_rd_valid), 0);
        checkOutput("idle_eng_rd_row", a_eng_rd_row, '0);
        checkOutput("idle_host_rd_row", a_host_rd_row, '0);

        $display("[TB] load identity out of order");
        host_write(2'd3, ident_row(3));
        check_val("load_busy", int'(a_busy), 1);
        host_write(2'd1, ident_row(1));
        host_write(2'd0, ident_row(0));
        host_write(2'd2, ident_row(2));
        pulse_load_done();
        check_val("serve_eng_wr_ready", int'(a_eng_wr_ready), 1);
        check_val("serve_host_wr_ready", int'(a_host_wr_ready), 0);

        $display("[TB] serve vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            check_val($sformatf("vec%0d_valid", i), int'(a_eng_rd_valid), int'(vecs[i].exp_v));
            if (vecs[i].exp_v) begin
                check_val($sformatf("vec%0d_addr", i), int'(a_eng_rd_addr), int'(vecs[i].exp_a));
                checkOutput($sformatf("vec%0d_row", i), a_eng_rd_row, vecs[i].exp_row);
            end
        end
        idle_engine();
        check_val("serve_err", int'(a_err), 0);

        $display("[TB] unload with stalls");
        exp_mem[0] = seq_row(7);
        exp_mem[1] = ident_row(1);
        exp_mem[2] = fill_row(D2, D3);
        exp_mem[3] = ident_row(3);
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;
        pulse_eng_done();
        run_unload();
        check_val("after_unload_err", int'(a_err), 0);

        $display("[TB] reset during unload");
        for (int i = 0; i < 4; i++) host_write(2'(i), seq_row(20 + i));
        pulse_load_done();
        pulse_eng_done();
        host_rd_ready = 1'b1;
        tick();
        host_rd_ready = 1'b0;
        check_val("mid_unload_addr", int'(a_host_rd_addr), 1);
        rst4 = 1'b1;
        tick();
        check_val("rst_unload_valid", int'(a_host_rd_valid), 0);
        check_val("rst_unload_busy", int'(a_busy), 0);
        rst4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            host_write(2'(i), seq_row(40 + i));
            exp_mem[i] = seq_row(40 + i);
            pat[i] = 1'b1;
        end
        pulse_load_done();
        pulse_eng_done();
        run_unload();

        $display("[TB] SIZE=3 error handling");
        rst4 = 1'b1;
        rst3 = 1'b0;
        tick();
        check_val("s3_idle_err", int'(b_err), 0);
        host_write(2'd0, seq_row(10));
        eng_rd_addr_valid = 1'b1;
        eng_rd_addr = 2'd1;
        tick();
        idle_engine();
        check_val("s3_load_rd_valid", int'(b_eng_rd_valid), 0);
        check_val("s3_load_rd_err", int'(b_err), 1);
        host_write(2'd1, seq_row(11));
        host_write(2'd2, seq_row(12));
        pulse_load_done();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs3[i]);
            check_val($sformatf("s3vec%0d_valid", i), int'(b_eng_rd_valid), int'(vecs3[i].exp_v));
            check_val($sformatf("s3vec%0d_addr", i), int'(b_eng_rd_addr), int'(vecs3[i].exp_a));
            checkOutput($sformatf("s3vec%0d_row", i), {128'd0, b_eng_rd_row}, {128'd0, vecs3[i].exp_row[383:0]});
        end
        idle_engine();
        check_val("s3_err_sticky", int'(b_err), 1);
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        tick();
        check_val("s3_err_cleared", int'(b_err), 0);

        $display("[TB] SIZE=3 simultaneous done pulses");
        host_write(2'd0, seq_row(30));
        host_load_done = 1'b1;
        eng_done = 1'b1;
        tick();
        host_load_done = 1'b0;
        eng_done = 1'b0;
        check_val("s3_dual_busy", int'(b_busy), 1);
        check_val("s3_dual_serve", int'(b_eng_wr_ready), 1);
        check_val("s3_dual_no_unload", int'(b_host_rd_valid), 0);
        check_val("s3_dual_err", int'(b_err), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
